// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation encoding and FSM states.
package seq_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHORT = 2'b01,
    ITER  = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv_core.sv
// Unsigned iterative engine: LSB-first shift-add multiplier and restoring
// divider sharing one hi/lo register pair. One iteration per cycle after start;
// o_done holds once WIDTH iterations are complete until the next cycle.
module seq_alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_mag_a,
  input  logic [WIDTH-1:0] i_mag_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_step;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  assign w_step  = r_busy && (r_cnt != LAST);
  assign o_done  = r_busy && (r_cnt == LAST);
  // Multiply: conditionally add multiplicand into the upper half, keep the carry.
  assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  // Divide: bring the next dividend bit into the remainder and trial-subtract.
  // The remainder is always below the divisor, so bit WIDTH of the trial is a
  // reliable "went negative" indicator.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_opb};

  // Iteration control: counts WIDTH steps and stops at LAST (never wraps).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_cnt  <= r_cnt + 1'b1;
    end else if (o_done) begin
      r_busy <= 1'b0;
    end
  end

  // Partial product / remainder datapath.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_div <= i_is_div;
      r_opb <= i_mag_b;
      r_hi  <= '0;
      r_lo  <= i_mag_a;
    end else if (w_step) begin
      if (r_div) begin
        if (!w_trial[WIDTH]) begin
          r_hi <= w_trial[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {r_hi, r_lo} <= {w_madd, r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: valid/ready handshake, one operation in flight.
// ADD/SUB and divide-by-zero finish in one cycle; MUL/DIV run through the
// iterative core with sign conditioning before and sign fix-up after.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] p_hi,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic             r_cond;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_sign;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_p_hi;
  logic             r_ov;
  logic             r_dbz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_start;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic             w_min_neg1;

  function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic add_ovf(input logic sg, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic [WIDTH:0] s);
    return sg ? ((x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1])) : s[WIDTH];
  endfunction

  function automatic logic sub_ovf(input logic sg, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic [WIDTH:0] s);
    return sg ? ((x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1])) : s[WIDTH];
  endfunction

  function automatic logic mul_ovf(input logic sg, input logic [2*WIDTH-1:0] pr);
    return sg ? (pr[2*WIDTH-1:WIDTH] != {WIDTH{pr[WIDTH-1]}})
              : (pr[2*WIDTH-1:WIDTH] != '0);
  endfunction

  assign in_ready    = (r_state == IDLE) && !rst;
  assign w_a_neg     = r_sign && r_a[WIDTH-1];
  assign w_b_neg     = r_sign && r_b[WIDTH-1];
  assign w_mag_a     = cneg(w_a_neg, r_a);
  assign w_mag_b     = cneg(w_b_neg, r_b);
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
  assign w_start     = (r_state == ITER) && r_cond;
  assign w_prod_fix  = (w_a_neg ^ w_b_neg) ? (~{w_core_hi, w_core_lo} + 1'b1)
                                           : {w_core_hi, w_core_lo};
  assign w_min_neg1  = r_sign && (r_a == MIN_VAL) && (r_b == '1);

  seq_alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_is_div (r_op == OP_DIV),
    .i_mag_a  (w_mag_a),
    .i_mag_b  (w_mag_b),
    .o_done   (w_core_done),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // Control FSM with registered results and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cond      <= 1'b0;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_p_hi      <= '0;
      r_ov        <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a    <= a;
            r_b    <= b;
            r_op   <= op;
            r_sign <= sign;
            if ((op == OP_ADD) || (op == OP_SUB) || ((op == OP_DIV) && (b == '0))) begin
              r_state <= SHORT;
            end else begin
              r_state <= ITER;
              r_cond  <= 1'b1;
            end
          end
        end
        // Single-cycle ops: ADD, SUB, divide by zero.
        SHORT: begin
          case (r_op)
            OP_ADD: begin
              r_p    <= w_sum[WIDTH-1:0];
              r_p_hi <= '0;
              r_ov   <= add_ovf(r_sign, r_a, r_b, w_sum);
              r_dbz  <= 1'b0;
            end
            OP_SUB: begin
              r_p    <= w_diff[WIDTH-1:0];
              r_p_hi <= '0;
              r_ov   <= sub_ovf(r_sign, r_a, r_b, w_diff);
              r_dbz  <= 1'b0;
            end
            default: begin
              r_p    <= '1;
              r_p_hi <= r_a;
              r_ov   <= 1'b0;
              r_dbz  <= 1'b1;
            end
          endcase
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        // Conditioning cycle starts the core; when it finishes, apply signs.
        ITER: begin
          if (r_cond) begin
            r_cond <= 1'b0;
          end else if (w_core_done) begin
            if (r_op == OP_MUL) begin
              {r_p_hi, r_p} <= w_prod_fix;
              r_ov          <= mul_ovf(r_sign, w_prod_fix);
            end else begin
              r_p    <= cneg(w_a_neg ^ w_b_neg, w_core_lo);
              r_p_hi <= cneg(w_a_neg, w_core_hi);
              r_ov   <= w_min_neg1;
            end
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign p           = r_p;
  assign p_hi        = r_p_hi;
  assign overflow    = r_ov;
  assign div_by_zero = r_dbz;

endmodule
